// File: rtl/connect4_pkg.sv
// connect4_pkg: shared constants and receiver state encoding for the Connect 4 design
package connect4_pkg;
   localparam int NUM_COLS = 7;
   localparam logic [3:0] MOVE_MARKER = 4'hA;
   typedef enum logic [2:0] {IDLE, SHIFT, CHECK, HOLD, ACK} rx_state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchroniser with a third flop for registered rise/fall pulses
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic s1, s2, s3;
   assign q = s3;
   // synchronise the pin, then compare the last two stages to flag edges aligned with q
   always_ff @(posedge clk) begin
      if (rst) begin
         {s1, s2, s3, rise, fall} <= '0;
      end else begin
         s1   <= d;
         s2   <= s1;
         s3   <= s2;
         rise <= s2 & ~s3;
         fall <= ~s2 & s3;
      end
   end
endmodule

// File: rtl/spi_move_receiver.sv
// spi_move_receiver: receives a remote move over SPI and offers it as a validated column
module spi_move_receiver
   import connect4_pkg::*;
#(
   parameter int FRAME_BITS = 8,
   parameter int ACK_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       ss,
   input  logic       mosi,
   input  logic       accept_en,
   input  logic       move_take,
   output logic [2:0] column,
   output logic       move_valid,
   output logic       pin_ack,
   output logic       frame_err
);
   rx_state_t state, state_nx;
   logic [FRAME_BITS-1:0] shift_reg;
   logic [3:0] bit_cnt;
   logic [15:0] ack_cnt;
   logic sck_rise, ss_q, ss_rise, ss_fall, mosi_q, frame_ok;
   logic unused_sck_q, unused_sck_fall, unused_mosi_rise, unused_mosi_fall;

   sync_edge u_sck  (.clk(clk), .rst(rst), .d(sck),  .q(unused_sck_q), .rise(sck_rise), .fall(unused_sck_fall));
   sync_edge u_ss   (.clk(clk), .rst(rst), .d(ss),   .q(ss_q),   .rise(ss_rise),  .fall(ss_fall));
   sync_edge u_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_q), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

   assign frame_ok = bit_cnt == 4'(FRAME_BITS)
                  && shift_reg[FRAME_BITS-1 -: 4] == MOVE_MARKER
                  && !shift_reg[3]
                  && 32'(shift_reg[2:0]) < NUM_COLS
                  && accept_en;
   assign move_valid = state == HOLD;
   assign pin_ack    = state == ACK;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state logic; ss rise wins over a coincident sck rise so that bit is dropped
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = ss_fall ? SHIFT : IDLE;
         SHIFT:   state_nx = ss_rise ? CHECK : SHIFT;
         CHECK:   state_nx = frame_ok ? HOLD : IDLE;
         HOLD:    state_nx = move_take ? ACK : HOLD;
         ACK:     state_nx = ack_cnt == '0 ? IDLE : ACK;
         default: state_nx = IDLE;
      endcase
   end

   // shift register, bit counter, latched column, ack timer and error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
         ack_cnt   <= '0;
         column    <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= state == CHECK && !frame_ok;
         if (state == IDLE && ss_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
         end else if (state == SHIFT && !ss_rise && sck_rise && !ss_q) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_q};
            bit_cnt   <= bit_cnt == 4'hF ? bit_cnt : bit_cnt + 4'd1;
         end
         if (state == CHECK && frame_ok) column <= shift_reg[2:0];
         if (state == HOLD && move_take) ack_cnt <= 16'(ACK_CYCLES - 1);
         else if (state == ACK && ack_cnt != '0) ack_cnt <= ack_cnt - 16'd1;
      end
   end
endmodule

// File: tb/tb_spi_move_receiver.sv
// tb_spi_move_receiver: directed vector table plus hand sequences for the SPI move receiver
module tb_spi_move_receiver;
   localparam int ACK = 2000;
   logic clk = 0, rst, sck, ss, mosi, accept_en, move_take;
   logic [2:0] column;
   logic move_valid, pin_ack, frame_err;
   int checks = 0, errors = 0;

   typedef struct {
      logic [15:0] bits;
      int          nbits;
      logic        acc;
      logic        exp_valid;
      logic [2:0]  exp_col;
   } vec_t;
   vec_t vecs[8];

   spi_move_receiver #(.FRAME_BITS(8), .ACK_CYCLES(ACK)) dut (
      .clk(clk), .rst(rst), .sck(sck), .ss(ss), .mosi(mosi), .accept_en(accept_en),
      .move_take(move_take), .column(column), .move_valid(move_valid), .pin_ack(pin_ack),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = bits[i];
         wait_clk(4);
         sck = 1;
         wait_clk(4);
         sck = 0;
      end
   endtask

   task automatic send_frame(input logic [15:0] bits, input int n);
      @(negedge clk);
      ss = 0;
      wait_clk(4);
      send_bits(bits, n);
      wait_clk(4);
      ss = 1;
   endtask

   task automatic observe(output int n_err, output int n_ack, output int lat);
      n_err = 0;
      n_ack = 0;
      lat = -1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
         if (frame_err) n_err++;
         if (pin_ack) n_ack++;
         if (move_valid && lat < 0) lat = i;
      end
   endtask

   task automatic take_move();
      int len;
      @(negedge clk);
      move_take = 1;
      @(posedge clk);
      #1;
      check("take_valid_drop", int'(move_valid), 0);
      check("take_ack_rise", int'(pin_ack), 1);
      @(negedge clk);
      move_take = 0;
      len = 1;
      for (int i = 0; i < ACK + 10; i++) begin
         @(posedge clk);
         #1;
         if (!pin_ack) break;
         len++;
      end
      check("ack_len", len, ACK);
      check("idle_after_ack_valid", int'(move_valid), 0);
   endtask

   initial begin
      int n_err, n_ack, lat;
      int cols[10] = '{0, 1, 2, 3, 4, 5, 6, 3, 5, 1};
      vecs[0] = '{16'h00A3, 8, 1'b1, 1'b1, 3'd3};
      vecs[1] = '{16'h00A7, 8, 1'b1, 1'b0, 3'd0};
      vecs[2] = '{16'h0053, 8, 1'b1, 1'b0, 3'd0};
      vecs[3] = '{16'h0028, 6, 1'b1, 1'b0, 3'd0};
      vecs[4] = '{16'h00A2, 8, 1'b0, 1'b0, 3'd0};
      vecs[5] = '{16'h00AB, 8, 1'b1, 1'b0, 3'd0};
      vecs[6] = '{16'h0147, 9, 1'b1, 1'b0, 3'd0};
      vecs[7] = '{16'h00A6, 8, 1'b1, 1'b1, 3'd6};
      rst = 1; ss = 1; sck = 0; mosi = 0; accept_en = 0; move_take = 0;
      wait_clk(3);
      check("rst_column", int'(column), 0);
      check("rst_valid", int'(move_valid), 0);
      check("rst_ack", int'(pin_ack), 0);
      check("rst_err", int'(frame_err), 0);
      rst = 0;
      wait_clk(6);
      move_take = 1;
      @(negedge clk);
      move_take = 0;
      observe(n_err, n_ack, lat);
      check("idle_take_ack", n_ack, 0);
      check("idle_take_valid", lat, -1);

      foreach (vecs[k]) begin
         accept_en = vecs[k].acc;
         send_frame(vecs[k].bits, vecs[k].nbits);
         observe(n_err, n_ack, lat);
         check($sformatf("vec%0d_err", k), n_err, vecs[k].exp_valid ? 0 : 1);
         check($sformatf("vec%0d_ack", k), n_ack, 0);
         check($sformatf("vec%0d_lat", k), lat, vecs[k].exp_valid ? 5 : -1);
         if (vecs[k].exp_valid) begin
            check($sformatf("vec%0d_col", k), int'(column), int'(vecs[k].exp_col));
            take_move();
         end
         accept_en = 1;
      end

      send_frame(16'h00A1, 8);
      observe(n_err, n_ack, lat);
      check("hold_first_col", int'(column), 1);
      accept_en = 0;
      send_frame(16'h00A5, 8);
      observe(n_err, n_ack, lat);
      check("hold_ignore_err", n_err, 0);
      check("hold_ignore_col", int'(column), 1);
      check("hold_keep_valid", int'(move_valid), 1);
      accept_en = 1;
      take_move();
      send_frame(16'h00A5, 8);
      observe(n_err, n_ack, lat);
      check("after_ack_lat", lat, 5);
      check("after_ack_col", int'(column), 5);
      take_move();

      @(negedge clk);
      ss = 0;
      wait_clk(4);
      send_bits(16'h000A, 4);
      rst = 1;
      @(negedge clk);
      rst = 0;
      ss = 1;
      observe(n_err, n_ack, lat);
      check("midrst_err", n_err, 0);
      check("midrst_valid", lat, -1);
      send_frame(16'h00A0, 8);
      observe(n_err, n_ack, lat);
      check("postrst_err", n_err, 0);
      check("postrst_lat", lat, 5);
      check("postrst_col", int'(column), 0);
      take_move();

      for (int i = 0; i < 10; i++) begin
         send_frame(16'h00A0 | 16'(cols[i]), 8);
         observe(n_err, n_ack, lat);
         check($sformatf("b2b%0d_lat", i), lat, 5);
         check($sformatf("b2b%0d_col", i), int'(column), cols[i]);
         take_move();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
